gaussian_line_filter: RTL and testbench
=======================================

Name: gaussian_line_filter

Overview:
- Parametrised successor to the fixed 13-tap horizontal blur.
- Applies a configurable symmetric FIR (Gaussian by default) along each video line, between the pixel source and the laser-line peak detector.
- Advances only on valid pixels and replicates edge pixels at line start and end, so it emits exactly one output per input pixel per line.
- Carries fvh sideband aligned to each output pixel and adds rounding, saturation, bypass and overrun detection.

Parameters:
- FILTER_SIZE, 5: tap count. Odd, 3..15. HALF = (FILTER_SIZE-1)/2.
- PX_WIDTH, 8: pixel width.
- COEF_WIDTH, 8: unsigned coefficient width.
- COEFFS, {8'd16,8'd64,8'd96,8'd64,8'd16}: packed taps. Tap 0 is in the LSBs and multiplies the oldest window pixel.
- NORM_SHIFT, 8: right shift after accumulation (default taps sum to 256).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fvh_in  in  3  {field, vblank, hblank} for px_in
- dv_in  in  1  px_in valid this cycle
- px_in  in  PX_WIDTH  input pixel
- bypass  in  1  1: output centre tap unfiltered. Sampled per output.
- fvh_out  out  3  sideband of the centre pixel of the output
- dv_out  out  1  one-cycle strobe, blurred_px valid
- blurred_px  out  PX_WIDTH  filtered pixel
- overrun  out  1  sticky; set when dv_in is dropped during FLUSH

Behaviour:
- reset low (async): state=IDLE; counters, window and sideband shift register cleared; dv_out=0, blurred_px=0, fvh_out=0, overrun=0.
- Window: FILTER_SIZE x PX_WIDTH shift register with a parallel fvh sideband register. It shifts only on a window-advance event (accepted dv_in or FLUSH injection). Centre tap = index HALF.

FSM:
- IDLE: on dv_in, load every window tap with px_in (edge replication) and every sideband tap with fvh_in. Set cnt=1, go FILL. If HALF=0 is impossible (FILTER_SIZE>=3), still go FILL.
- FILL: each dv_in shifts in, cnt++. On the dv_in making cnt==HALF+1, the centre holds line pixel 0; an output is launched and the state goes RUN. No outputs are launched before this.
- RUN: each dv_in shifts in and launches one output.
- Line end, from FILL or RUN: rising edge of fvh_in[0] (hblank 0->1, registered compare) goes to FLUSH with flush_cnt = min(HALF, pixels received).
- FLUSH: each clock, inject a copy of the newest window pixel and its sideband, and launch one output. When flush_cnt reaches 0, go IDLE.
- Short lines (fewer than HALF+1 pixels, entered from FILL): the FILL-state shifts plus FLUSH still produce exactly N outputs for N inputs. Outputs are the centre pixels 0..N-1 with replicated edges.
- dv_in asserted during FLUSH: pixel dropped and overrun<=1. overrun clears only on reset.
- dv_in and hblank rising in the same cycle: the pixel is accepted first, then FLUSH.

Datapath pipeline (2 registered stages after a launch):
- S1: acc = sum(COEFFS[i]*window[i]), width PX_WIDTH+COEF_WIDTH+4, unsigned. The centre tap and fvh are also registered.
- S2: r = (acc + (1<<(NORM_SHIFT-1))) >> NORM_SHIFT. Saturate to 2^PX_WIDTH-1.
  - blurred_px = bypass ? centre : r.
  - fvh_out = centre sideband; dv_out=1 for one clock.
- Latency: dv_out rises exactly 2 clocks after the launching event. Outputs are back-to-back capable, one per clock.
- Between outputs, dv_out=0 and blurred_px/fvh_out hold their last value.

Test Plan:
- Flat line, 20 px of value 100, dv_in every other clock, then hblank rise -> 20 dv_out pulses, all blurred_px=100. Last 2 pulses come 1 clock apart during FLUSH. overrun=0.
- Impulse: 20 px of 0 with 255 at x=10 -> outputs x8..x12 = 16,64,96,64,16; all other outputs 0. fvh_out matches each pixel's input fvh.
- Short line: 1 px of value 200 then hblank rise -> exactly 1 output of 200. FSM returns to IDLE and the next line starts cleanly.
- Saturation: COEFFS all 8'd255, all px 255 -> every blurred_px=255, no wrap.
- bypass=1: ramp 0..19 -> outputs 0..19 unchanged, latency still 2 clocks after launch.
- Reset low asserted mid-RUN with dv_in active -> immediately dv_out=0, blurred_px=0. After release, the next line produces correct outputs with no stale pixels. Forcing dv_in during FLUSH -> overrun=1 and that pixel is dropped.

Source files
------------

// File: rtl/gaussian_line_filter.sv
// Configurable symmetric FIR along each video line with edge replication, fvh
// sideband alignment, rounding/saturation, bypass and sticky overrun flag.
module gaussian_line_filter #(
  parameter int FILTER_SIZE = 5,
  parameter int PX_WIDTH    = 8,
  parameter int COEF_WIDTH  = 8,
  parameter logic [FILTER_SIZE*COEF_WIDTH-1:0] COEFFS = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16},
  parameter int NORM_SHIFT  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          fvh_in,
  input  logic                dv_in,
  input  logic [PX_WIDTH-1:0] px_in,
  input  logic                bypass,
  output logic [2:0]          fvh_out,
  output logic                dv_out,
  output logic [PX_WIDTH-1:0] blurred_px,
  output logic                overrun
);

  localparam int HALF  = (FILTER_SIZE - 1) / 2;
  localparam int ACC_W = PX_WIDTH + COEF_WIDTH + 4;
  localparam int CNT_W = $clog2(FILTER_SIZE + 1);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] FILL_DONE = CNT_W'(HALF + 1);
  localparam logic [ACC_W:0]   RND       = (ACC_W + 1)'(1) << (NORM_SHIFT - 1);
  localparam logic [ACC_W:0]   PX_MAX    = (ACC_W + 1)'((1 << PX_WIDTH) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    flush_cnt_r;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [CNT_W-1:0]    fill_cnt_s;
  logic                hblank_prev_r;
  logic                hb_rise_s;
  logic                launch_r;
  logic [PX_WIDTH-1:0] win_r [FILTER_SIZE];
  logic [2:0]          sb_r  [FILTER_SIZE];
  logic                adv_s;
  logic                load_s;
  logic [PX_WIDTH-1:0] adv_px_s;
  logic [2:0]          adv_fvh_s;
  logic [ACC_W-1:0]    acc_s;
  logic [ACC_W-1:0]    acc_r;
  logic [PX_WIDTH-1:0] centre_r;
  logic [2:0]          cfvh_r;
  logic                v1_r;
  logic [ACC_W:0]      rnd_sum_s;
  logic [ACC_W:0]      shifted_s;
  logic [PX_WIDTH-1:0] sat_s;

  function automatic logic [CNT_W-1:0] min_half(input logic [CNT_W-1:0] n);
    return (n < HALF_C) ? n : HALF_C;
  endfunction

  // Window-advance decode: accepted pixels while filling/running, newest-pixel copies while flushing
  always_comb begin
    hb_rise_s  = fvh_in[0] & ~hblank_prev_r;
    cnt_inc_s  = cnt_r + CNT_W'(1);
    fill_cnt_s = dv_in ? cnt_inc_s : cnt_r;
    adv_s      = 1'b0;
    load_s     = 1'b0;
    adv_px_s   = px_in;
    adv_fvh_s  = fvh_in;
    case (state_r)
      IDLE: begin
        if (dv_in) load_s = 1'b1;
        else       load_s = 1'b0;
      end
      FILL, RUN: begin
        if (dv_in) adv_s = 1'b1;
        else       adv_s = 1'b0;
      end
      FLUSH: begin
        adv_s     = (flush_cnt_r != CNT_W'(0));
        adv_px_s  = win_r[FILTER_SIZE-1];
        adv_fvh_s = sb_r[FILTER_SIZE-1];
      end
      default: adv_s = 1'b0;
    endcase
  end

  // Pixel window and parallel sideband shift register; index FILTER_SIZE-1 is newest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FILTER_SIZE; i++) begin
        win_r[i] <= '0;
        sb_r[i]  <= 3'd0;
      end
    end else if (load_s) begin
      for (int i = 0; i < FILTER_SIZE; i++) begin
        win_r[i] <= px_in;
        sb_r[i]  <= fvh_in;
      end
    end else if (adv_s) begin
      for (int i = 0; i < FILTER_SIZE - 1; i++) begin
        win_r[i] <= win_r[i+1];
        sb_r[i]  <= sb_r[i+1];
      end
      win_r[FILTER_SIZE-1] <= adv_px_s;
      sb_r[FILTER_SIZE-1]  <= adv_fvh_s;
    end
  end

  // Line-control FSM: launches outputs, tracks fill depth and flush length, flags overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      flush_cnt_r   <= '0;
      hblank_prev_r <= 1'b0;
      launch_r      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      hblank_prev_r <= fvh_in[0];
      launch_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (dv_in) begin
            cnt_r <= CNT_W'(1);
            if (hb_rise_s) begin
              state_r     <= FLUSH;
              flush_cnt_r <= CNT_W'(1);
            end else begin
              state_r <= FILL;
            end
          end
        end
        FILL: begin
          if (dv_in) cnt_r <= cnt_inc_s;
          if (dv_in && cnt_inc_s == FILL_DONE) launch_r <= 1'b1;
          // A same-cycle pixel is counted before the flush length is fixed
          if (hb_rise_s) begin
            state_r     <= FLUSH;
            flush_cnt_r <= min_half(fill_cnt_s);
          end else if (dv_in && cnt_inc_s == FILL_DONE) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          launch_r <= dv_in;
          if (hb_rise_s) begin
            state_r     <= FLUSH;
            flush_cnt_r <= HALF_C;
          end
        end
        FLUSH: begin
          if (dv_in) overrun <= 1'b1;
          if (flush_cnt_r != CNT_W'(0)) begin
            launch_r    <= 1'b1;
            flush_cnt_r <= flush_cnt_r - CNT_W'(1);
            if (flush_cnt_r == CNT_W'(1)) state_r <= IDLE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Multiply-accumulate over the window, then round and clamp the stage-1 sum
  always_comb begin
    acc_s = '0;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      acc_s = acc_s + ACC_W'(COEFFS[i*COEF_WIDTH +: COEF_WIDTH]) * ACC_W'(win_r[i]);
    end
    rnd_sum_s = {1'b0, acc_r} + RND;
    shifted_s = rnd_sum_s >> NORM_SHIFT;
    sat_s     = (shifted_s > PX_MAX) ? {PX_WIDTH{1'b1}} : shifted_s[PX_WIDTH-1:0];
  end

  // Stage 1: capture accumulator, centre pixel and centre sideband of a launched window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r     <= 1'b0;
      acc_r    <= '0;
      centre_r <= '0;
      cfvh_r   <= 3'd0;
    end else begin
      v1_r <= launch_r;
      if (launch_r) begin
        acc_r    <= acc_s;
        centre_r <= win_r[HALF];
        cfvh_r   <= sb_r[HALF];
      end
    end
  end

  // Stage 2: registered outputs; pixel and sideband hold between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_out     <= 1'b0;
      blurred_px <= '0;
      fvh_out    <= 3'd0;
    end else begin
      dv_out <= v1_r;
      if (v1_r) begin
        blurred_px <= bypass ? centre_r : sat_s;
        fvh_out    <= cfvh_r;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_line_filter.sv
// Self-checking bench: two filter instances (default taps and all-255 taps) share
// the stimulus; outputs are compared against a clamp-index convolution model.
module tb_gaussian_line_filter;

  localparam int FS   = 5;
  localparam int HALF = (FS - 1) / 2;
  localparam int CF [FS] = '{16, 64, 96, 64, 16};

  logic       clk;
  logic       reset;
  logic [2:0] fvh_in;
  logic       dv_in;
  logic [7:0] px_in;
  logic       bypass;
  logic [2:0] fvh_out_a, fvh_out_b;
  logic       dv_out_a, dv_out_b;
  logic [7:0] blurred_px_a, blurred_px_b;
  logic       overrun_a, overrun_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hb_t;
  int base_a, base_b;
  int lp[$];
  int lf[$];
  int in_t[$];
  int out_a_px[$];
  int out_a_fvh[$];
  int out_a_t[$];
  int out_b_px[$];

  gaussian_line_filter dut_a (
    .clk(clk), .reset(reset), .fvh_in(fvh_in), .dv_in(dv_in), .px_in(px_in),
    .bypass(bypass), .fvh_out(fvh_out_a), .dv_out(dv_out_a),
    .blurred_px(blurred_px_a), .overrun(overrun_a)
  );

  gaussian_line_filter #(
    .FILTER_SIZE(5), .PX_WIDTH(8), .COEF_WIDTH(8),
    .COEFFS({5{8'd255}}), .NORM_SHIFT(8)
  ) dut_b (
    .clk(clk), .reset(reset), .fvh_in(fvh_in), .dv_in(dv_in), .px_in(px_in),
    .bypass(bypass), .fvh_out(fvh_out_b), .dv_out(dv_out_b),
    .blurred_px(blurred_px_b), .overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv_out_a) begin
      out_a_px.push_back(int'(blurred_px_a));
      out_a_fvh.push_back(int'(fvh_out_a));
      out_a_t.push_back(cyc);
    end
    if (dv_out_b) out_b_px.push_back(int'(blurred_px_b));
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int idx, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  // Reference: out[x] = sum_i c[i] * p[clamp(x + i - HALF)], rounded, saturated
  function automatic int model_px(input int x, input int n, input bit all255, input bit byp);
    int s = 0;
    int idx;
    int r;
    if (byp) return lp[x];
    for (int i = 0; i < FS; i++) begin
      idx = x + i - HALF;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      s += (all255 ? 255 : CF[i]) * lp[idx];
    end
    r = (s + 128) / 256;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic gen_line(input int n, input int kind);
    lp.delete();
    lf.delete();
    for (int k = 0; k < n; k++) begin
      case (kind)
        1: lp.push_back(100);
        2: lp.push_back((k == 10) ? 255 : 0);
        3: lp.push_back(200);
        4: lp.push_back(k);
        5: lp.push_back(255);
        default: lp.push_back(int'($urandom_range(0, 255)));
      endcase
      lf.push_back(int'($urandom_range(0, 3)) * 2);
    end
  endtask

  task automatic send_line(input int n, input int mode, input bit inject);
    int g;
    in_t.delete();
    base_a = out_a_px.size();
    base_b = out_b_px.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      dv_in  = 1'b1;
      px_in  = 8'(lp[k]);
      fvh_in = 3'(lf[k]);
      in_t.push_back(cyc + 1);
      g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int q = 0; q < g; q++) begin
        @(negedge clk);
        dv_in = 1'b0;
        px_in = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    dv_in     = 1'b0;
    fvh_in[0] = 1'b1;
    hb_t      = cyc + 1;
    if (inject) begin
      @(negedge clk);
      dv_in = 1'b1;
      px_in = 8'd77;
    end
    @(negedge clk);
    dv_in = 1'b0;
    repeat (8) @(negedge clk);
    fvh_in[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_line(input int n, input bit byp, input string tag);
    int k = 0;
    int ga, gb, nf, et;
    while ((out_a_px.size() - base_a < n || out_b_px.size() - base_b < n) && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (4) @(negedge clk);
    #1;
    ga = out_a_px.size() - base_a;
    gb = out_b_px.size() - base_b;
    chk({tag, "_count_a"}, 0, ga, n);
    chk({tag, "_count_b"}, 0, gb, n);
    nf = (n < HALF) ? n : HALF;
    for (int j = 0; j < n && j < ga; j++) begin
      et = (j < n - nf) ? in_t[j + HALF] + 2 : hb_t + 3 + (j - (n - nf));
      chk({tag, "_px_a"}, j, out_a_px[base_a + j], model_px(j, n, 1'b0, byp));
      chk({tag, "_fvh_a"}, j, out_a_fvh[base_a + j], lf[j]);
      chk({tag, "_time_a"}, j, out_a_t[base_a + j], et);
    end
    for (int j = 0; j < n && j < gb; j++) begin
      chk({tag, "_px_b"}, j, out_b_px[base_b + j], model_px(j, n, 1'b1, byp));
    end
  endtask

  initial begin
    int n;
    int lit [5];
    lit = '{16, 64, 96, 64, 16};
    reset  = 1'b0;
    dv_in  = 1'b0;
    fvh_in = 3'd0;
    px_in  = 8'd0;
    bypass = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dv_out", 0, int'(dv_out_a), 0);
    chk("rst_blurred", 0, int'(blurred_px_a), 0);
    chk("rst_fvh_out", 0, int'(fvh_out_a), 0);
    chk("rst_overrun", 0, int'(overrun_a), 0);
    chk("rst_dv_out_b", 0, int'(dv_out_b), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    gen_line(20, 1);
    send_line(20, 1, 1'b0);
    check_line(20, 1'b0, "flat");
    chk("flat_overrun", 0, int'(overrun_a), 0);

    gen_line(20, 2);
    send_line(20, 2, 1'b0);
    check_line(20, 1'b0, "impulse");
    if (out_a_px.size() - base_a >= 13) begin
      for (int j = 0; j < 5; j++) chk("impulse_lit", j + 8, out_a_px[base_a + 8 + j], lit[j]);
    end

    gen_line(1, 3);
    send_line(1, 0, 1'b0);
    check_line(1, 1'b0, "short1");
    gen_line(2, 0);
    send_line(2, 1, 1'b0);
    check_line(2, 1'b0, "short2");
    gen_line(12, 0);
    send_line(12, 2, 1'b0);
    check_line(12, 1'b0, "after_short");

    gen_line(15, 5);
    send_line(15, 0, 1'b0);
    check_line(15, 1'b0, "sat");

    bypass = 1'b1;
    gen_line(20, 4);
    send_line(20, 0, 1'b0);
    check_line(20, 1'b1, "bypass");
    bypass = 1'b0;

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 25));
      gen_line(n, 0);
      send_line(n, 2, 1'b0);
      check_line(n, 1'b0, "rand");
    end

    gen_line(10, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dv_in  = 1'b1;
      px_in  = 8'(lp[k]);
      fvh_in = 3'(lf[k]);
    end
    @(negedge clk);
    px_in = 8'($urandom_range(0, 255));
    #1;
    chk("pre_reset_dv", 0, int'(dv_out_a), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_dv", 0, int'(dv_out_a), 0);
    chk("mid_reset_px", 0, int'(blurred_px_a), 0);
    chk("mid_reset_fvh", 0, int'(fvh_out_a), 0);
    chk("mid_reset_dv_b", 0, int'(dv_out_b), 0);
    dv_in  = 1'b0;
    fvh_in = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    gen_line(14, 0);
    send_line(14, 0, 1'b0);
    check_line(14, 1'b0, "post_reset");

    gen_line(9, 0);
    send_line(9, 0, 1'b1);
    check_line(9, 1'b0, "overrun_line");
    chk("overrun_a", 0, int'(overrun_a), 1);
    chk("overrun_b", 0, int'(overrun_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
